layer_stream_driver: RTL and testbench
======================================

# layer_stream_driver

Stream source and sink for a neural-network layer block. The host loads one N-element input vector into a local buffer and pulses `start`. The block then sends the vector to the layer's `s_valid/s_ready/data_in` port, collects the M result words from the layer's `m_valid/m_ready/data_out` port into a result buffer, and signals `done`. It is the driver-side counterpart of the `layer_*` blocks and is used both as the SoC-side adapter and as the reusable bench driver.

## Interface
- WIDTH, 16, data word width (signed)
- N, 8, input vector length
- M, 6, output vector length
- LOGN, 3, ld_addr width, ≥ clog2(N)
- LOGM, 3, rd_addr width, ≥ clog2(M)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- ld_valid  in  1  host write strobe into the vector buffer
- ld_addr  in  LOGN  vector buffer write index
- ld_data  in  WIDTH  vector buffer write data
- start  in  1  begin one transaction (pulse)
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse when all M results are stored
- rd_addr  in  LOGM  result buffer read index
- rd_data  out  WIDTH  result word, registered
- lat_cycles  out  16  cycles spent in SEND+RECV for the last transaction, saturating
- m_valid  out  1  vector word valid, connects to layer s_valid
- m_ready  in  1  layer accepts a word, connects to layer s_ready
- data_out  out  WIDTH  vector word, connects to layer data_in
- s_valid  in  1  layer result valid, connects to layer m_valid
- s_ready  out  1  driver accepts a result, connects to layer m_ready
- data_in  in  WIDTH  layer result, connects to layer data_out

## Operation
- States: IDLE, SEND, RECV, DONE.
- IDLE:
  - If ld_valid=1 and ld_addr<N, write vec[ld_addr]<=ld_data. If ld_addr≥N, ignore the write.
  - start=1 moves to SEND: tx_cnt<=0, lat<=0.
  - ld_valid and start in the same cycle: the write is committed first and the transmitted vector includes it.
- SEND:
  - m_valid=1 and data_out=vec[tx_cnt].
  - m_valid never depends on m_ready. The layer asserts s_ready only after seeing valid.
  - A handshake is m_valid&&m_ready. On a handshake, tx_cnt++.
  - On the handshake with tx_cnt==N-1, go to RECV with rx_cnt<=0. m_valid is 0 the next cycle.
  - While m_ready=0, m_valid and data_out hold stable.
- RECV:
  - s_ready=1. On s_valid&&s_ready, res[rx_cnt]<=data_in and rx_cnt++.
  - On the handshake with rx_cnt==M-1, go to DONE.
  - s_ready is 0 in every other state. s_valid outside RECV is ignored and does not block.
- DONE: done=1 and busy=1 for one cycle, lat_cycles<=lat, then go to IDLE.
- lat increments on every cycle in SEND or RECV and saturates at 16'hFFFF.
- Ignored inputs:
  - start while busy.
  - ld_valid while busy. Vector contents are frozen during a transaction.
- rd_data<=res[rd_addr] every cycle, or 0 if rd_addr≥M. It is readable in any state, including mid-RECV, where partially updated results are visible.
- Arithmetic: none on data. Words pass through bit-exact with no sign manipulation.

## Timing
- Reset (reset=0, asynchronous): state=IDLE; tx_cnt, rx_cnt, lat=0; vec[] and res[] cleared to 0.
- Output values on reset:
  - m_valid=0, s_ready=0, busy=0, done=0.
  - data_out=0, rd_data=0, lat_cycles=0.
- Reset released mid-transaction: the block resumes in IDLE and no partial done is ever issued.
- start sampled at edge t gives busy=1 and m_valid=1 from t+1.
- With m_ready=1 and s_valid=1 held constantly:
  - N sends occur on edges t+1..t+N.
  - s_ready is high from t+N+1.
  - M receives occur on edges t+N+1..t+N+M.
  - done is high during cycle t+N+M+1.
  - lat_cycles=N+M.
- rd_data latency is 1 cycle from rd_addr.
- data_out is combinational from vec[tx_cnt] and changes only after a handshake edge.

## Test plan
- Basic transaction with defaults:
  - Stimulus: load vec=1..8, start, m_ready=1, responder returns 10..15 with s_valid=1 throughout.
  - Required: the layer sees 1..8 in order, done pulses once, rd_addr 0..5 read back 10..15, lat_cycles=14.
- Backpressure:
  - Stimulus: m_ready alternates 0/1 starting at 0; s_valid alternates 0/1.
  - Required: data_out is stable while stalled, each word is sent exactly once, lat_cycles=28, results are correct.
- Ignored inputs:
  - Stimulus: start pulses and ld_valid writes of 16'h7FFF issued during SEND.
  - Required: no restart, the vector is unchanged, exactly one done.
  - Stimulus: ld_addr=9 write and rd_addr=7 read in IDLE.
  - Required: no buffer change, rd_data=0.
- Reset mid-transaction:
  - Stimulus: reset=0 asserted at tx_cnt=3.
  - Required: all outputs 0 immediately (asynchronous), done never asserts, rd_data=0.
  - Stimulus: a new load and start after reset release.
  - Required: the transaction completes normally.
- Edge cases:
  - Stimulus: ld_valid with ld_addr=0 and data -5, issued in the same cycle as start.
  - Required: the first word sent is 16'hFFFB.
  - Stimulus: a transaction with m_ready held low for 70000 cycles.
  - Required: lat_cycles saturates at 16'hFFFF.

Source files
------------

// File: rtl/layer_stream_driver.sv
// rtl/layer_stream_driver.sv - vector source / result sink driving one layer block over valid/ready streams
module layer_stream_driver #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int M     = 6,
    parameter int LOGN  = 3,
    parameter int LOGM  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    input  logic [LOGN-1:0]  ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [LOGM-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [15:0]      lat_cycles,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] data_out,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] data_in
);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    localparam logic [LOGN:0]   N_EXT   = (LOGN+1)'(N);
    localparam logic [LOGM:0]   M_EXT   = (LOGM+1)'(M);
    localparam logic [LOGN-1:0] TX_LAST = LOGN'(N - 1);
    localparam logic [LOGM-1:0] RX_LAST = LOGM'(M - 1);

    state_t           state;
    logic [WIDTH-1:0] vec [2**LOGN];
    logic [WIDTH-1:0] res [2**LOGM];
    logic [LOGN-1:0]  tx_cnt;
    logic [LOGM-1:0]  rx_cnt;
    logic [15:0]      lat;

    // Handshake controls decode directly from the state register, so m_valid never looks at m_ready.
    assign m_valid  = (state == SEND);
    assign s_ready  = (state == RECV);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign data_out = m_valid ? vec[tx_cnt] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            lat        <= '0;
            lat_cycles <= '0;
            rd_data    <= '0;
            vec        <= '{default: '0};
            res        <= '{default: '0};
        end else begin
            rd_data <= ({1'b0, rd_addr} < M_EXT) ? res[rd_addr] : '0;

            if ((state == SEND || state == RECV) && lat != 16'hFFFF) begin
                lat <= lat + 16'd1;
            end

            case (state)
                IDLE: begin
                    // A load in the start cycle lands in vec on the same edge, so it is transmitted.
                    if (ld_valid && ({1'b0, ld_addr} < N_EXT)) begin
                        vec[ld_addr] <= ld_data;
                    end
                    if (start) begin
                        state  <= SEND;
                        tx_cnt <= '0;
                        lat    <= '0;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        tx_cnt <= tx_cnt + 1'b1;
                        if (tx_cnt == TX_LAST) begin
                            state  <= RECV;
                            rx_cnt <= '0;
                        end
                    end
                end
                RECV: begin
                    if (s_valid) begin
                        res[rx_cnt] <= data_in;
                        rx_cnt      <= rx_cnt + 1'b1;
                        if (rx_cnt == RX_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    lat_cycles <= lat;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_stream_driver.sv
// tb/tb_layer_stream_driver.sv - randomized bench with a transaction-level layer model for layer_stream_driver
module tb_layer_stream_driver;

    localparam int WIDTH = 16;
    localparam int N     = 8;
    localparam int M     = 6;
    localparam int LOGN  = 4;
    localparam int LOGM  = 3;

    localparam int P_IDLE = 0;
    localparam int P_SEND = 1;
    localparam int P_RECV = 2;
    localparam int P_DONE = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             ld_valid;
    logic [LOGN-1:0]  ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic             start;
    logic             busy;
    logic             done;
    logic [LOGM-1:0]  rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [15:0]      lat_cycles;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] data_out;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] data_in;

    always #5 clk = ~clk;

    layer_stream_driver #(
        .WIDTH(WIDTH), .N(N), .M(M), .LOGN(LOGN), .LOGM(LOGM)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .lat_cycles(lat_cycles),
        .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out),
        .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: buffer contents, the vector snapshot taken at start, and the layer's replies.
    logic [WIDTH-1:0] vec_m    [N];
    logic [WIDTH-1:0] res_m    [M];
    logic [WIDTH-1:0] snap     [N];
    logic [WIDTH-1:0] resp     [M];
    logic [WIDTH-1:0] sent_log [N];
    int phase    = P_IDLE;
    bit go       = 1'b0;
    int mode     = 0;
    int cyc      = 0;
    int tx_k     = 0;
    int rx_k     = 0;
    int lat_m    = 0;
    int done_cnt = 0;

    function automatic bit pick_ready(input int md, input int c);
        case (md)
            0:       return 1'b1;
            1:       return c[0];
            2:       return 1'($urandom_range(1, 0));
            default: return (c >= 70000);
        endcase
    endfunction

    // Layer responder: drives m_ready/s_valid/data_in at negedge and checks what the driver presents.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (go) begin
            go    = 1'b0;
            phase = P_SEND;
            cyc   = 0;
            tx_k  = 0;
            rx_k  = 0;
            lat_m = 0;
        end else begin
            case (phase)
                P_SEND: begin
                    compared++;
                    if ({m_valid, s_ready, busy} !== 3'b101) begin
                        mismatched++;
                        $display("FAIL send_ctrl: m_valid/s_ready/busy=%b expected 101", {m_valid, s_ready, busy});
                    end
                    compared++;
                    if (data_out !== snap[tx_k]) begin
                        mismatched++;
                        $display("FAIL send_data[%0d]: got %h expected %h", tx_k, data_out, snap[tx_k]);
                    end
                    if (lat_m < 65535) lat_m++;
                    m_ready = pick_ready(mode, cyc);
                    s_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
                    data_in = resp[0];
                    cyc++;
                    if (m_ready) begin
                        sent_log[tx_k] = data_out;
                        tx_k++;
                        if (tx_k == N) begin
                            phase = P_RECV;
                            cyc   = 0;
                        end
                    end
                end
                P_RECV: begin
                    compared++;
                    if ({m_valid, s_ready, busy} !== 3'b011) begin
                        mismatched++;
                        $display("FAIL recv_ctrl: m_valid/s_ready/busy=%b expected 011", {m_valid, s_ready, busy});
                    end
                    if (lat_m < 65535) lat_m++;
                    m_ready = 1'($urandom_range(1, 0));
                    s_valid = (mode == 3) ? 1'b1 : pick_ready(mode, cyc);
                    data_in = resp[rx_k];
                    cyc++;
                    if (s_valid) begin
                        res_m[rx_k] = resp[rx_k];
                        rx_k++;
                        if (rx_k == M) phase = P_DONE;
                    end
                end
                P_DONE: begin
                    compared++;
                    if ({done, busy, s_ready, m_valid} !== 4'b1100) begin
                        mismatched++;
                        $display("FAIL done_cycle: done/busy/s_ready/m_valid=%b expected 1100", {done, busy, s_ready, m_valid});
                    end
                    phase = P_IDLE;
                end
                default: begin
                    compared++;
                    if (done !== 1'b0) begin
                        mismatched++;
                        $display("FAIL idle_done: done=%b expected 0", done);
                    end
                    m_ready = 1'($urandom_range(1, 0));
                    s_valid = 1'($urandom_range(1, 0));
                    data_in = WIDTH'($urandom);
                end
            endcase
        end
    end

    task automatic ld_word(input int addr, input logic [WIDTH-1:0] d);
        @(posedge clk); #1;
        ld_valid = 1'b1;
        ld_addr  = LOGN'(addr);
        ld_data  = d;
        if (addr < N) vec_m[addr] = d;
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++) ld_word(i, WIDTH'($urandom));
        for (int i = 0; i < M; i++) resp[i] = WIDTH'($urandom);
    endtask

    task automatic do_start(input int md);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = md;
        for (int i = 0; i < N; i++) snap[i] = vec_m[i];
        go = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_txn();
        int n = 0;
        while (phase != P_IDLE || go) begin
            @(posedge clk); #1;
            n++;
            if (n > 80000) begin
                compared++;
                mismatched++;
                $display("FAIL txn_timeout: transaction still in phase %0d after %0d cycles", phase, n);
                phase = P_IDLE;
            end
        end
    endtask

    task automatic rd_word(input int a, output logic [WIDTH-1:0] d);
        @(posedge clk); #1;
        rd_addr = LOGM'(a);
        @(posedge clk); #1;
        d = rd_data;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        compared++;
        if ({m_valid, s_ready, busy, done} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_ctrl: m_valid/s_ready/busy/done=%b expected 0000", {m_valid, s_ready, busy, done});
        end
        compared++;
        if (data_out !== '0) begin mismatched++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        compared++;
        if (rd_data !== '0) begin mismatched++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        compared++;
        if (lat_cycles !== 16'h0) begin mismatched++; $display("FAIL reset_lat: got %h expected 0", lat_cycles); end
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] d;
        int dc;
        for (int i = 0; i < N; i++) ld_word(i, WIDTH'(i + 1));
        for (int i = 0; i < M; i++) resp[i] = WIDTH'(i + 10);
        dc = done_cnt;
        do_start(0);
        wait_txn();
        compared++;
        if (lat_cycles !== 16'd14) begin mismatched++; $display("FAIL basic_lat: got %0d expected 14", lat_cycles); end
        compared++;
        if (done_cnt - dc != 1) begin mismatched++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - dc); end
        for (int i = 0; i < N; i++) begin
            compared++;
            if (sent_log[i] !== WIDTH'(i + 1)) begin
                mismatched++;
                $display("FAIL basic_sent[%0d]: got %h expected %h", i, sent_log[i], WIDTH'(i + 1));
            end
        end
        for (int i = 0; i < M; i++) begin
            rd_word(i, d);
            compared++;
            if (d !== WIDTH'(i + 10)) begin mismatched++; $display("FAIL basic_rd[%0d]: got %h expected %h", i, d, WIDTH'(i + 10)); end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] d;
        load_random();
        do_start(1);
        wait_txn();
        compared++;
        if (lat_cycles !== 16'd28) begin mismatched++; $display("FAIL bp_lat: got %0d expected 28", lat_cycles); end
        for (int i = 0; i < M; i++) begin
            rd_word(i, d);
            compared++;
            if (d !== res_m[i]) begin mismatched++; $display("FAIL bp_rd[%0d]: got %h expected %h", i, d, res_m[i]); end
        end
    endtask

    task automatic test_random_flow();
        logic [WIDTH-1:0] d;
        for (int t = 0; t < 4; t++) begin
            load_random();
            do_start(2);
            wait_txn();
            compared++;
            if (lat_cycles !== 16'(lat_m)) begin mismatched++; $display("FAIL rand_lat: got %0d expected %0d", lat_cycles, lat_m); end
            rd_word($urandom_range(M - 1, 0), d);
            compared++;
            if (d !== res_m[rd_addr]) begin mismatched++; $display("FAIL rand_rd[%0d]: got %h expected %h", rd_addr, d, res_m[rd_addr]); end
        end
    endtask

    task automatic test_ignored();
        logic [WIDTH-1:0] d;
        int dc;
        load_random();
        dc = done_cnt;
        do_start(2);
        for (int k = 0; k < 6 && phase == P_SEND && tx_k < N - 1; k++) begin
            start    = 1'b1;
            ld_valid = 1'b1;
            ld_addr  = LOGN'($urandom_range(N - 1, 0));
            ld_data  = 16'h7FFF;
            @(posedge clk); #1;
            start    = 1'b0;
            ld_valid = 1'b0;
            @(posedge clk); #1;
        end
        wait_txn();
        compared++;
        if (done_cnt - dc != 1) begin mismatched++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt - dc); end
        compared++;
        if (lat_cycles !== 16'(lat_m)) begin mismatched++; $display("FAIL ign_lat: got %0d expected %0d", lat_cycles, lat_m); end
        // Out-of-range load and read in IDLE; the follow-up transaction re-checks every vector word.
        ld_word(9, 16'h1234);
        rd_word(7, d);
        compared++;
        if (d !== '0) begin mismatched++; $display("FAIL ign_rd_oob: got %h expected 0", d); end
        do_start(0);
        wait_txn();
        compared++;
        if (lat_cycles !== 16'd14) begin mismatched++; $display("FAIL ign_lat2: got %0d expected 14", lat_cycles); end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] d;
        int dc;
        int n = 0;
        load_random();
        do_start(0);
        while (tx_k < 3 && n < 100) begin @(posedge clk); #1; n++; end
        #2 reset = 1'b0;
        #1;
        phase = P_IDLE;
        for (int i = 0; i < N; i++) vec_m[i] = '0;
        for (int i = 0; i < M; i++) res_m[i] = '0;
        dc = done_cnt;
        compared++;
        if ({m_valid, s_ready, busy, done} !== 4'b0000) begin
            mismatched++;
            $display("FAIL rst_mid_ctrl: m_valid/s_ready/busy/done=%b expected 0000", {m_valid, s_ready, busy, done});
        end
        compared++;
        if ({data_out, rd_data, lat_cycles} !== '0) begin
            mismatched++;
            $display("FAIL rst_mid_data: data_out/rd_data/lat=%h/%h/%h expected 0", data_out, rd_data, lat_cycles);
        end
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        rd_word(0, d);
        compared++;
        if (d !== '0) begin mismatched++; $display("FAIL rst_mid_rd: got %h expected 0", d); end
        repeat (5) @(posedge clk);
        compared++;
        if (done_cnt != dc) begin mismatched++; $display("FAIL rst_mid_no_done: got %0d extra dones expected 0", done_cnt - dc); end
        load_random();
        do_start(2);
        wait_txn();
        compared++;
        if (lat_cycles !== 16'(lat_m)) begin mismatched++; $display("FAIL rst_mid_relat: got %0d expected %0d", lat_cycles, lat_m); end
        rd_word(M - 1, d);
        compared++;
        if (d !== res_m[M - 1]) begin mismatched++; $display("FAIL rst_mid_rerd: got %h expected %h", d, res_m[M - 1]); end
    endtask

    task automatic test_same_cycle_load();
        for (int i = 0; i < M; i++) resp[i] = WIDTH'($urandom);
        @(posedge clk); #1;
        ld_valid  = 1'b1;
        ld_addr   = '0;
        ld_data   = -16'sd5;
        vec_m[0]  = 16'hFFFB;
        start     = 1'b1;
        mode      = 0;
        for (int i = 0; i < N; i++) snap[i] = vec_m[i];
        go = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        ld_valid = 1'b0;
        wait_txn();
        compared++;
        if (sent_log[0] !== 16'hFFFB) begin mismatched++; $display("FAIL same_cycle_first: got %h expected fffb", sent_log[0]); end
    endtask

    task automatic test_saturation();
        do_start(3);
        wait_txn();
        compared++;
        if (lat_cycles !== 16'hFFFF) begin mismatched++; $display("FAIL sat_lat: got %h expected ffff", lat_cycles); end
    endtask

    initial begin
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        start    = 1'b0;
        rd_addr  = '0;
        m_ready  = 1'b0;
        s_valid  = 1'b0;
        data_in  = '0;
        for (int i = 0; i < N; i++) vec_m[i] = '0;
        for (int i = 0; i < M; i++) begin res_m[i] = '0; resp[i] = '0; end
        test_reset();
        test_basic();
        test_backpressure();
        test_random_flow();
        test_ignored();
        test_reset_mid();
        test_same_cycle_load();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
